// File: rtl/micro_sequencer_if.sv
// Decode-to-sequencer handshake and micro-op output bundle.
// The decode/control side holds the master modport; the sequencer holds the slave modport.
interface micro_sequencer_if;
   logic        flush_pipeline;
   logic        in_valid;
   logic [91:0] idecode_cu_interface;
   logic        cu_stall;
   logic        seq_ready;
   logic        uop_valid;
   logic [7:0]  uop_addr;
   logic [2:0]  uop_index;
   logic        uop_last;
   logic [31:0] uop_instr;
   logic        uop_br_pred;
   logic [7:0]  uop_br_addr;
   logic [7:0]  uop_nt_addr;
   logic        busy;

   modport master (
      output flush_pipeline, in_valid, idecode_cu_interface, cu_stall,
      input  seq_ready, uop_valid, uop_addr, uop_index, uop_last,
             uop_instr, uop_br_pred, uop_br_addr, uop_nt_addr, busy
   );

   modport slave (
      input  flush_pipeline, in_valid, idecode_cu_interface, cu_stall,
      output seq_ready, uop_valid, uop_addr, uop_index, uop_last,
             uop_instr, uop_br_pred, uop_br_addr, uop_nt_addr, busy
   );
endinterface

// File: rtl/micro_sequencer.sv
// Expands each decoded instruction into ucnt+1 consecutive microcode ROM addresses.
// state  | meaning
// S_IDLE | no micro-op on the outputs; ready for a new entry unless stalled
// S_RUN  | emitting base+idx; new entry accepted only on the last micro-op
module micro_sequencer (
   input  logic              clk,
   input  logic              rst,
   micro_sequencer_if.slave  sif
);
   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t      state_q, state_n;
   logic [7:0]  base_q, base_n;
   logic [2:0]  cnt_q, cnt_n;
   logic [2:0]  idx_q, idx_n;
   logic [31:0] instr_q, instr_n;
   logic        pred_q, pred_n;
   logic [7:0]  br_addr_q, br_addr_n;
   logic [7:0]  nt_addr_q, nt_addr_n;

   logic [91:0] bus;
   logic [31:0] d_instr;
   logic [7:0]  d_uaddr;
   logic [2:0]  d_ucnt;
   logic [7:0]  d_nt_addr;
   logic [7:0]  d_br_addr;
   logic        d_pred;
   logic        unused_bits;

   assign bus         = sif.idecode_cu_interface;
   assign d_instr     = bus[31:0];
   assign d_uaddr     = bus[39:32];
   assign d_ucnt      = bus[42:40];
   assign d_nt_addr   = bus[82:75];
   assign d_br_addr   = bus[90:83];
   assign d_pred      = bus[91];
   assign unused_bits = ^bus[74:43];

   logic active, last, ready, accept;

   assign active = (state_q == S_RUN);
   assign last   = active && (idx_q == cnt_q);
   assign ready  = !sif.cu_stall && (!active || last);
   assign accept = sif.in_valid && ready && !sif.flush_pipeline;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         instr_q   <= '0;
         pred_q    <= 1'b0;
         br_addr_q <= '0;
         nt_addr_q <= '0;
      end else begin
         state_q   <= state_n;
         base_q    <= base_n;
         cnt_q     <= cnt_n;
         idx_q     <= idx_n;
         instr_q   <= instr_n;
         pred_q    <= pred_n;
         br_addr_q <= br_addr_n;
         nt_addr_q <= nt_addr_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      base_n    = base_q;
      cnt_n     = cnt_q;
      idx_n     = idx_q;
      instr_n   = instr_q;
      pred_n    = pred_q;
      br_addr_n = br_addr_q;
      nt_addr_n = nt_addr_q;
      if (sif.flush_pipeline) begin
         // Flush keeps the latched instruction/branch fields for later inspection.
         state_n = S_IDLE;
         idx_n   = '0;
      end else if (accept) begin
         instr_n   = d_instr;
         pred_n    = d_pred;
         br_addr_n = d_br_addr;
         nt_addr_n = d_nt_addr;
         idx_n     = '0;
         if (d_uaddr != 8'hFF) begin
            state_n = S_RUN;
            base_n  = d_uaddr;
            cnt_n   = d_ucnt;
         end else begin
            state_n = S_IDLE;
         end
      end else if (active && !sif.cu_stall) begin
         if (idx_q < cnt_q) begin
            idx_n = idx_q + 3'd1;
         end else begin
            state_n = S_IDLE;
            idx_n   = '0;
         end
      end
   end

   assign sif.seq_ready   = ready;
   assign sif.uop_valid   = active;
   assign sif.uop_addr    = base_q + {5'b0, idx_q};
   assign sif.uop_index   = idx_q;
   assign sif.uop_last    = last;
   assign sif.busy        = active && !last;
   assign sif.uop_instr   = instr_q;
   assign sif.uop_br_pred = pred_q;
   assign sif.uop_br_addr = br_addr_q;
   assign sif.uop_nt_addr = nt_addr_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench: directed vector table, reset corner case, and random traffic
// compared against a queue-of-pending-micro-ops reference model.
module tb_micro_sequencer;
   logic clk;
   logic rst;

   micro_sequencer_if sif ();

   micro_sequencer dut (
      .clk (clk),
      .rst (rst),
      .sif (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic logic [91:0] mk(input logic [31:0] ins, input logic [7:0] ua,
                                      input logic [2:0] uc, input logic [7:0] nt,
                                      input logic [7:0] br, input logic pr,
                                      input logic [31:0] junk);
      return {pr, br, nt, junk, uc, ua, ins};
   endfunction

   typedef struct {
      logic       iv;
      logic [7:0] ua;
      logic [2:0] uc;
      logic       st;
      logic       fl;
      logic       ev;
      logic [7:0] ea;
      logic [2:0] ei;
      logic       el;
      logic       er;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic iv, input logic [7:0] ua, input logic [2:0] uc,
                      input logic st, input logic fl, input logic ev,
                      input logic [7:0] ea, input logic [2:0] ei,
                      input logic el, input logic er);
      vec_t v;
      v.iv = iv; v.ua = ua; v.uc = uc; v.st = st; v.fl = fl;
      v.ev = ev; v.ea = ea; v.ei = ei; v.el = el; v.er = er;
      vecs.push_back(v);
   endtask

   // Reference model: the outstanding micro-ops of the current instruction, in order.
   typedef struct {
      logic [7:0] addr;
      logic [2:0] idx;
   } uop_t;

   uop_t        mq[$];
   logic [31:0] m_instr;
   logic        m_pred;
   logic [7:0]  m_br;
   logic [7:0]  m_nt;

   task automatic drive(input logic iv, input logic [91:0] b, input logic st, input logic fl);
      sif.in_valid             = iv;
      sif.idecode_cu_interface = b;
      sif.cu_stall             = st;
      sif.flush_pipeline       = fl;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0);
      #3;
      chk("rst_valid", 32'(sif.uop_valid), 32'd0);
      chk("rst_addr", 32'(sif.uop_addr), 32'h00);
      chk("rst_index", 32'(sif.uop_index), 32'd0);
      chk("rst_last", 32'(sif.uop_last), 32'd0);
      chk("rst_busy", 32'(sif.busy), 32'd0);
      chk("rst_instr", sif.uop_instr, 32'd0);
      chk("rst_branch", 32'({sif.uop_br_pred, sif.uop_br_addr, sif.uop_nt_addr}), 32'd0);
      chk("rst_ready", 32'(sif.seq_ready), 32'd1);
      sif.cu_stall = 1'b1;
      #1;
      chk("rst_ready_stall", 32'(sif.seq_ready), 32'd0);
      sif.cu_stall = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      next_cycle();

      // in_valid, uaddr, ucnt, stall, flush | valid, addr, index, last, ready
      add(1, 8'h05, 0, 0, 0,  0, 8'h00, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0,  1, 8'h05, 0, 1, 1);
      add(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 1);
      add(1, 8'h0A, 2, 0, 0,  0, 8'h00, 0, 0, 1);
      add(1, 8'h31, 0, 0, 0,  1, 8'h0A, 0, 0, 0);
      add(1, 8'h31, 0, 0, 0,  1, 8'h0B, 1, 0, 0);
      add(1, 8'h31, 0, 0, 0,  1, 8'h0C, 2, 1, 1);
      add(0, 8'h00, 0, 0, 0,  1, 8'h31, 0, 1, 1);
      add(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 1);
      add(1, 8'h3A, 2, 0, 0,  0, 8'h00, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0,  1, 8'h3A, 0, 0, 0);
      add(0, 8'h00, 0, 1, 0,  1, 8'h3B, 1, 0, 0);
      add(0, 8'h00, 0, 1, 0,  1, 8'h3B, 1, 0, 0);
      add(0, 8'h00, 0, 1, 0,  1, 8'h3B, 1, 0, 0);
      add(0, 8'h00, 0, 0, 0,  1, 8'h3B, 1, 0, 0);
      add(0, 8'h00, 0, 0, 0,  1, 8'h3C, 2, 1, 1);
      add(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 1);
      add(1, 8'h10, 2, 0, 0,  0, 8'h00, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0,  1, 8'h10, 0, 0, 0);
      add(1, 8'h55, 0, 0, 1,  1, 8'h11, 1, 0, 0);
      add(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 1);
      add(1, 8'h20, 0, 0, 1,  0, 8'h00, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 1);
      add(1, 8'hFF, 0, 0, 0,  0, 8'h00, 0, 0, 1);
      add(1, 8'hFE, 2, 0, 0,  0, 8'h00, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0,  1, 8'hFE, 0, 0, 0);
      add(0, 8'h00, 0, 0, 0,  1, 8'hFF, 1, 0, 0);
      add(0, 8'h00, 0, 0, 0,  1, 8'h00, 2, 1, 1);
      add(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 1);
      add(1, 8'hF0, 7, 0, 0,  0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 8; i++)
         add(0, 8'h00, 0, 0, 0, 1, 8'hF0 + 8'(i), 3'(i), (i == 7), (i == 7));
      add(0, 8'h00, 0, 0, 0,  0, 8'h00, 0, 0, 1);

      foreach (vecs[k]) begin
         drive(vecs[k].iv, mk(32'h0, vecs[k].ua, vecs[k].uc, 8'h0, 8'h0, 1'b0, 32'h0),
               vecs[k].st, vecs[k].fl);
         #2;
         chk($sformatf("t%0d_valid", k), 32'(sif.uop_valid), 32'(vecs[k].ev));
         if (vecs[k].ev) chk($sformatf("t%0d_addr", k), 32'(sif.uop_addr), 32'(vecs[k].ea));
         chk($sformatf("t%0d_index", k), 32'(sif.uop_index), 32'(vecs[k].ei));
         chk($sformatf("t%0d_last", k), 32'(sif.uop_last), 32'(vecs[k].el));
         chk($sformatf("t%0d_ready", k), 32'(sif.seq_ready), 32'(vecs[k].er));
         chk($sformatf("t%0d_busy", k), 32'(sif.busy), 32'(vecs[k].ev && !vecs[k].el));
         next_cycle();
      end

      // Async reset mid-sequence, then a clean restart.
      drive(1'b1, mk(32'hCAFEF00D, 8'h80, 3'd7, 8'h11, 8'h22, 1'b1, 32'h0), 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, '0, 1'b0, 1'b0);
      next_cycle();
      next_cycle();
      chk("mid_addr", 32'(sif.uop_addr), 32'h82);
      chk("mid_instr", sif.uop_instr, 32'hCAFEF00D);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(sif.uop_valid), 32'd0);
      chk("arst_addr", 32'(sif.uop_addr), 32'h00);
      chk("arst_index", 32'(sif.uop_index), 32'd0);
      chk("arst_busy", 32'(sif.busy), 32'd0);
      chk("arst_instr", sif.uop_instr, 32'd0);
      chk("arst_branch", 32'({sif.uop_br_pred, sif.uop_br_addr, sif.uop_nt_addr}), 32'd0);
      chk("arst_ready", 32'(sif.seq_ready), 32'd1);
      next_cycle();
      rst = 1'b0;
      drive(1'b1, mk(32'h12345678, 8'h40, 3'd1, 8'h0, 8'h0, 1'b0, 32'h0), 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      chk("restart_valid", 32'(sif.uop_valid), 32'd1);
      chk("restart_addr", 32'(sif.uop_addr), 32'h40);
      chk("restart_index", 32'(sif.uop_index), 32'd0);

      // Random traffic against the queue model, starting from a fresh reset.
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      mq.delete();
      m_instr = '0; m_pred = 1'b0; m_br = '0; m_nt = '0;
      for (int c = 0; c < 3000; c++) begin
         logic        iv, st, fl, e_ready, acc;
         logic [7:0]  ua, nt, br;
         logic [2:0]  uc;
         logic [31:0] ins;
         logic        pr;
         iv  = ($urandom_range(0, 3) != 0);
         st  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 15) == 0);
         ua  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         uc  = 3'($urandom);
         ins = $urandom;
         nt  = 8'($urandom);
         br  = 8'($urandom);
         pr  = 1'($urandom);
         drive(iv, mk(ins, ua, uc, nt, br, pr, $urandom), st, fl);
         #2;
         e_ready = !st && (mq.size() <= 1);
         chk("r_valid", 32'(sif.uop_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) begin
            chk("r_addr", 32'(sif.uop_addr), 32'(mq[0].addr));
            chk("r_index", 32'(sif.uop_index), 32'(mq[0].idx));
         end else begin
            chk("r_index", 32'(sif.uop_index), 32'd0);
         end
         chk("r_last", 32'(sif.uop_last), 32'(mq.size() == 1));
         chk("r_busy", 32'(sif.busy), 32'(mq.size() > 1));
         chk("r_ready", 32'(sif.seq_ready), 32'(e_ready));
         chk("r_instr", sif.uop_instr, m_instr);
         chk("r_branch", 32'({sif.uop_br_pred, sif.uop_br_addr, sif.uop_nt_addr}),
             32'({m_pred, m_br, m_nt}));
         acc = iv && e_ready && !fl;
         if (fl) begin
            mq.delete();
         end else begin
            if (!st && mq.size() != 0) void'(mq.pop_front());
            if (acc) begin
               m_instr = ins; m_pred = pr; m_br = br; m_nt = nt;
               if (ua != 8'hFF)
                  for (int i = 0; i <= int'(uc); i++) begin
                     uop_t u;
                     u.addr = ua + 8'(i);
                     u.idx  = 3'(i);
                     mq.push_back(u);
                  end
            end
         end
         next_cycle();
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
